// File: rtl/addsub_16bit_seq.sv
`default_nettype none
// ============================================================================
//  Module   : addsub_16bit_seq
//  Purpose  : Multi-cycle two's-complement add/subtract. A single SLICE-bit
//             adder with carry-in is stepped across the operands one slice
//             per cycle, LSB slice first, with the inter-slice carry held in
//             a register. Produces an optionally saturated result plus the
//             V/Z/N flags for the flag register.
//  Ports    : clk, rst_n (async, active low)
//             start, A, B, sub, sat  - request and operands, sampled when idle
//             busy                   - high while slices are being processed
//             done                   - one-cycle pulse, Sum/flags valid
//             Sum, Ovfl, Z, N        - result and flags, held until next done
//  Revision : 1.0  initial release
// ============================================================================
module addsub_16bit_seq #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  input  logic             sat,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Ovfl,
  output logic             Z,
  output logic             N
);

  localparam int c_NSL = WIDTH / SLICE;
  localparam int c_IW  = (c_NSL > 1) ? $clog2(c_NSL) : 1;
  localparam logic [c_IW-1:0] c_LAST = c_IW'(c_NSL - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [WIDTH-1:0] c_SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] c_SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_bx;     // B, already inverted for subtraction
  logic [WIDTH-1:0] r_res;    // raw result, filled a slice at a time
  logic             r_sat;
  logic             r_carry;
  logic [c_IW-1:0]  r_idx;

  logic             w_accept;
  logic             w_last;
  logic [SLICE-1:0] w_sl_a;
  logic [SLICE-1:0] w_sl_b;
  logic [SLICE:0]   w_sl_sum;
  logic             w_cin_msb;
  logic             w_ovf;
  logic [WIDTH-1:0] w_raw;
  logic [WIDTH-1:0] w_final;

  assign w_accept = start && (r_state != S_RUN);
  assign w_last   = (r_idx == c_LAST);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_RUN);
    done = (r_state == S_DONE);
  end

  // ---------------------------------------------------------------- slice
  always_comb begin
    w_sl_a = '0;
    w_sl_b = '0;
    for (int i = 0; i < c_NSL; i++) begin
      if (r_idx == c_IW'(i)) begin
        w_sl_a = r_a[i*SLICE +: SLICE];
        w_sl_b = r_bx[i*SLICE +: SLICE];
      end
    end
  end

  assign w_sl_sum = {1'b0, w_sl_a} + {1'b0, w_sl_b} + {{SLICE{1'b0}}, r_carry};

  // Carry into the slice MSB recovered from its sum bit; only meaningful on
  // the last slice, where it is the carry into bit WIDTH-1.
  assign w_cin_msb = w_sl_a[SLICE-1] ^ w_sl_b[SLICE-1] ^ w_sl_sum[SLICE-1];
  assign w_ovf     = w_cin_msb ^ w_sl_sum[SLICE];

  // Full raw result on the last slice: earlier slices from the register,
  // the top slice straight from the adder.
  always_comb begin
    w_raw = r_res;
    w_raw[WIDTH-1 -: SLICE] = w_sl_sum[SLICE-1:0];
  end

  // Saturation direction follows the sign of A: an overflow can only occur
  // when the effective operands share A's sign.
  assign w_final = (r_sat && w_ovf) ? (r_a[WIDTH-1] ? c_SAT_NEG : c_SAT_POS)
                                    : w_raw;

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_bx    <= '0;
      r_res   <= '0;
      r_sat   <= 1'b0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      Sum     <= '0;
      Ovfl    <= 1'b0;
      Z       <= 1'b0;
      N       <= 1'b0;
    end else if (w_accept) begin
      r_a     <= A;
      r_bx    <= B ^ {WIDTH{sub}};
      r_sat   <= sat;
      r_carry <= sub;             // +1 completes the two's-complement negate
      r_idx   <= '0;
    end else if (r_state == S_RUN) begin
      for (int i = 0; i < c_NSL; i++) begin
        if (r_idx == c_IW'(i)) r_res[i*SLICE +: SLICE] <= w_sl_sum[SLICE-1:0];
      end
      r_carry <= w_sl_sum[SLICE];
      r_idx   <= r_idx + 1'b1;
      if (w_last) begin
        Sum  <= w_final;
        Ovfl <= w_ovf;
        Z    <= (w_final == '0);
        N    <= w_final[WIDTH-1];
      end
    end
  end

endmodule
`default_nettype wire
